// File: rtl/alsu_sink_pkg.sv
// Shared types and helpers for the ALSU result sink: FIFO entry layout and
// the saturating accumulate used by the statistics path.
package alsu_sink_pkg;

  localparam int RESULT_W = 6;
  localparam int LEDS_W   = 16;

  typedef struct packed {
    logic                       err;
    logic signed [RESULT_W-1:0] result;
  } sink_entry_t;

  // Operands arrive sign-extended to 32 bits; w is the real accumulator width.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [31:0] val,
                                                 input int                 w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = acc + val;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/alsu_sink_fifo.sv
// First-word-fall-through FIFO for sink entries. Accepts a push while full
// only when the head is popped in the same cycle; otherwise the push is dropped.
module alsu_sink_fifo
  import alsu_sink_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req_i,
  input  sink_entry_t              wr_data_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output sink_entry_t              rd_data_o,
  output logic                     accept_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  sink_entry_t mem_q [DEPTH];
  logic        full;
  logic        pop;

  // Pointers carry one extra bit so the difference distinguishes full from empty.
  assign level_o    = wr_q - rd_q;
  assign full       = (level_o == FULL_LVL);
  assign rd_valid_o = (level_o != '0);
  assign pop        = rd_valid_o && rd_ready_i;
  assign accept_o   = push_req_i && (!full || pop);
  assign drop_o     = push_req_i && full && !pop;
  assign rd_data_o  = rd_valid_o ? mem_q[rd_q[AW-1:0]] : '0;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (accept_o) wr_d = wr_q + (AW+1)'(1);
    if (pop)      rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_o) mem_q[wr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/alsu_result_sink.sv
// Consumer of registered ALSU results: flags samples taken across an LED
// change, buffers them in a FWFT FIFO and keeps saturating statistics.
module alsu_result_sink
  import alsu_sink_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [RESULT_W-1:0] out,
  input  logic [LEDS_W-1:0]          leds,
  input  logic                       clear,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [RESULT_W-1:0] m_result,
  output logic                       m_err,
  output logic signed [ACC_W-1:0]    acc,
  output logic [CNT_W-1:0]           sample_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       dropped,
  output logic [$clog2(DEPTH):0]     level
);

  logic [LEDS_W-1:0]       leds_prev_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        sample_q, sample_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]        drop_q, drop_d;
  logic                    dropped_q, dropped_d;
  logic                    err;
  logic                    accept;
  logic                    drop;
  sink_entry_t             wr_entry;
  sink_entry_t             head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // The ALSU toggles its LED bank on an invalid op, so any change marks the sample.
  assign err               = (leds != leds_prev_q);
  assign wr_entry.err      = err;
  assign wr_entry.result   = out;

  alsu_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (in_valid),
    .wr_data_i  (wr_entry),
    .rd_ready_i (m_ready),
    .rd_valid_o (m_valid),
    .rd_data_o  (head),
    .accept_o   (accept),
    .drop_o     (drop),
    .level_o    (level)
  );

  assign m_result = head.result;
  assign m_err    = head.err;

  // clear wins over a same-cycle update; the FIFO still takes the push.
  always_comb begin
    acc_d     = acc_q;
    sample_d  = sample_q;
    err_cnt_d = err_cnt_q;
    drop_d    = drop_q;
    dropped_d = dropped_q;
    if (clear) begin
      acc_d     = '0;
      sample_d  = '0;
      err_cnt_d = '0;
      drop_d    = '0;
      dropped_d = 1'b0;
    end else begin
      if (accept) begin
        sample_d = sat_inc(sample_q);
        if (err) err_cnt_d = sat_inc(err_cnt_q);
        else     acc_d     = ACC_W'(sat_add(32'(acc_q), 32'(out), ACC_W));
      end
      if (drop) begin
        drop_d    = sat_inc(drop_q);
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_prev_q <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      err_cnt_q   <= '0;
      drop_q      <= '0;
      dropped_q   <= 1'b0;
    end else begin
      leds_prev_q <= leds;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      err_cnt_q   <= err_cnt_d;
      drop_q      <= drop_d;
      dropped_q   <= dropped_d;
    end
  end

  assign acc        = acc_q;
  assign sample_cnt = sample_q;
  assign err_cnt    = err_cnt_q;
  assign drop_cnt   = drop_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_alsu_result_sink.sv
// Bench for alsu_result_sink: queue-based reference model compared every
// negedge, plus directed scenarios with hand-computed literal expectations.
module tb_alsu_result_sink;

  localparam int DEPTH = 8;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;
  localparam int ACC_MAX = 2047;
  localparam int ACC_MIN = -2048;
  localparam int CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid;
  logic signed [5:0] out;
  logic [15:0]       leds;
  logic              clear;
  logic              m_valid;
  logic              m_ready;
  logic signed [5:0] m_result;
  logic              m_err;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]  sample_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              dropped;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  alsu_result_sink #(.DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .out        (out),
    .leds       (leds),
    .clear      (clear),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_result   (m_result),
    .m_err      (m_err),
    .acc        (acc),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt),
    .dropped    (dropped),
    .level      (level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of entries plus plain-integer statistics.
  typedef struct {
    bit err;
    int res;
  } ent_t;

  ent_t        mq[$];
  int          m_acc, m_samp, m_errc, m_drop;
  bit          m_dropped;
  logic [15:0] m_prev;
  bit          m_pop, m_push, m_e;

  function automatic int inc_sat(input int c);
    return (c < CNT_MAX) ? c + 1 : CNT_MAX;
  endfunction

  function automatic int clamp(input int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_acc = 0; m_samp = 0; m_errc = 0; m_drop = 0;
      m_dropped = 0;
      m_prev = '0;
    end else begin
      m_pop  = (mq.size() > 0) && m_ready;
      m_push = in_valid && ((mq.size() < DEPTH) || m_pop);
      m_e    = (leds != m_prev);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{err: m_e, res: int'(out)});
      if (clear) begin
        m_acc = 0; m_samp = 0; m_errc = 0; m_drop = 0;
        m_dropped = 0;
      end else begin
        if (m_push) begin
          m_samp = inc_sat(m_samp);
          if (m_e) m_errc = inc_sat(m_errc);
          else     m_acc  = clamp(m_acc + int'(out));
        end
        if (in_valid && !m_push) begin
          m_drop = inc_sat(m_drop);
          m_dropped = 1;
        end
      end
      m_prev = leds;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", int'(m_valid), (mq.size() > 0) ? 1 : 0);
      if (mq.size() > 0) begin
        chk("m_result", int'(m_result), mq[0].res);
        chk("m_err", int'(m_err), int'(mq[0].err));
      end else begin
        chk("m_result_idle", int'(m_result), 0);
        chk("m_err_idle", int'(m_err), 0);
      end
      chk("level", int'(level), mq.size());
      chk("acc", int'(acc), m_acc);
      chk("sample_cnt", int'(sample_cnt), m_samp);
      chk("err_cnt", int'(err_cnt), m_errc);
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("dropped", int'(dropped), int'(m_dropped));
    end
  end

  task automatic step(input bit iv, input int o, input logic [15:0] l,
                      input bit clr, input bit rdy);
    in_valid = iv;
    out      = o[5:0];
    leds     = l;
    clear    = clr;
    m_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; out = '0; leds = '0; clear = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_sample", int'(sample_cnt), 0);
    rst = 0;

    // Three pushes, no drain
    step(1, 5, 16'h0000, 0, 0);
    chk("t1_valid_lat", int'(m_valid), 1);
    chk("t1_head", int'(m_result), 5);
    step(1, -3, 16'h0000, 0, 0);
    step(1, 31, 16'h0000, 0, 0);
    chk("t1_level", int'(level), 3);
    chk("t1_acc", int'(acc), 33);
    chk("t1_sample", int'(sample_cnt), 3);
    chk("t1_errcnt", int'(err_cnt), 0);
    chk("t1_head_still", int'(m_result), 5);
    repeat (3) step(0, 0, 16'h0000, 0, 1);
    chk("t1_drained", int'(level), 0);

    // LED toggles mark both samples as errors
    step(1, 0, 16'hFFFF, 0, 0);
    step(1, 0, 16'h0000, 0, 0);
    chk("t2_errcnt", int'(err_cnt), 2);
    chk("t2_acc", int'(acc), 33);
    chk("t2_level", int'(level), 2);
    chk("t2_head_err", int'(m_err), 1);
    step(0, 0, 16'h0000, 0, 1);
    chk("t2_second_err", int'(m_err), 1);
    step(0, 0, 16'h0000, 0, 1);

    // Overflow: 10 pushes into 8 entries
    repeat (10) step(1, 1, 16'h0000, 0, 0);
    chk("t3_level", int'(level), 8);
    chk("t3_drop", int'(drop_cnt), 2);
    chk("t3_dropped", int'(dropped), 1);
    chk("t3_acc", int'(acc), 41);
    chk("t3_sample", int'(sample_cnt), 13);
    step(1, 2, 16'h0000, 0, 1);
    chk("t3_full_pop_level", int'(level), 8);
    chk("t3_full_pop_drop", int'(drop_cnt), 2);
    repeat (8) step(0, 0, 16'h0000, 0, 1);

    // Accumulator saturation both ways, sample counter saturation
    repeat (70) step(1, 31, 16'h0000, 0, 1);
    chk("t4_acc_max", int'(acc), 2047);
    chk("t4_sample", int'(sample_cnt), 84);
    repeat (180) step(1, -32, 16'h0000, 0, 1);
    chk("t4_acc_min", int'(acc), -2048);
    chk("t4_sample_sat", int'(sample_cnt), 255);
    step(0, 0, 16'h0000, 0, 1);
    chk("t4_drained", int'(level), 0);

    // clear with a same-cycle push
    step(1, 7, 16'h0000, 1, 0);
    chk("t5_acc", int'(acc), 0);
    chk("t5_sample", int'(sample_cnt), 0);
    chk("t5_dropped", int'(dropped), 0);
    chk("t5_drop", int'(drop_cnt), 0);
    chk("t5_level", int'(level), 1);
    chk("t5_head", int'(m_result), 7);

    // Async reset mid-drain
    repeat (3) step(1, 4, 16'h0000, 0, 0);
    chk("t6_level4", int'(level), 4);
    in_valid = 0;
    m_ready  = 1;
    #2;
    rst = 1;
    #1;
    chk("t6_rst_valid", int'(m_valid), 0);
    chk("t6_rst_level", int'(level), 0);
    @(posedge clk);
    #1;
    rst = 0;
    step(1, 9, 16'h0000, 0, 1);
    chk("t6_post_valid", int'(m_valid), 1);
    chk("t6_post_head", int'(m_result), 9);
    repeat (2) step(0, 0, 16'h0000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
